// File: rtl/sevenseg_scanner.sv
// sevenseg_scanner: time-multiplexed scan controller for a common-anode
// seven-segment display. One nibble is presented per digit slot. The anode
// for a slot is held off for the first GUARD cycles of the slot to suppress
// ghosting. Display updates are double-buffered and applied only at frame
// boundaries, so a frame never shows a mix of old and new digits.
//
// Load handshake (valid/ready): a transfer happens on a rising clk edge
// where load_valid && load_ready. load_ready depends only on registered
// state. Once the source raises load_valid, it must hold load_valid,
// load_value and load_dp stable until that transfer edge. Nothing is
// captured while load_ready is low.
module sevenseg_scanner #(
    parameter int NDIGITS = 4,
    parameter int DIV     = 1000,
    parameter int GUARD   = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [4*NDIGITS-1:0]   load_value,
    input  logic [NDIGITS-1:0]     load_dp,
    input  logic                   blank_lz,
    output logic [3:0]             digit,
    output logic                   dp,
    output logic [NDIGITS-1:0]     an_n,
    output logic                   frame_start
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NDIGITS - 1);

    // Scan position within the frame.
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;

    // Displayed and pending display buffers.
    logic [4*NDIGITS-1:0] disp_value;
    logic [NDIGITS-1:0]   disp_dp;
    logic [4*NDIGITS-1:0] pend_value;
    logic [NDIGITS-1:0]   pend_dp;
    logic                 pend_full;

    logic                 tick;
    logic                 boundary;
    logic                 accept;
    logic [4*NDIGITS-1:0] upper_nibbles;
    logic                 lz_blank;
    logic                 slot_lit;

    // Slot and frame boundary decode; accept is the handshake transfer.
    always_comb begin
        tick       = (cnt == CNT_LAST);
        boundary   = tick && (idx == IDX_LAST);
        load_ready = !pend_full;
        accept     = load_valid && load_ready;
    end

    // Free-running slot counter, digit index and the registered frame pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            idx         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= boundary;
            if (tick) begin
                cnt <= '0;
                if (idx == IDX_LAST) begin
                    idx <= '0;
                end else begin
                    idx <= idx + IW'(1);
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Double buffer. A pending value is promoted at the frame boundary. An
    // offer that arrives exactly at a boundary, with the pending buffer
    // empty, goes straight to the display buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_value <= '0;
            disp_dp    <= '0;
            pend_value <= '0;
            pend_dp    <= '0;
            pend_full  <= 1'b0;
        end else begin
            if (boundary && pend_full) begin
                disp_value <= pend_value;
                disp_dp    <= pend_dp;
                pend_full  <= 1'b0;
            end else if (boundary && accept) begin
                disp_value <= load_value;
                disp_dp    <= load_dp;
            end else if (accept) begin
                pend_value <= load_value;
                pend_dp    <= load_dp;
                pend_full  <= 1'b1;
            end
        end
    end

    // Leading-zero test: the current digit and every more significant
    // digit are zero. Digit 0 is never blanked.
    always_comb begin
        upper_nibbles = disp_value >> (4 * idx);
        lz_blank      = blank_lz && (idx != '0) && (upper_nibbles == '0);
        slot_lit      = (cnt >= CNT_GUARD) && !lz_blank;
    end

    // Output mux: nibble, decimal point and the one-cold anode for the slot.
    always_comb begin
        digit = 4'h0;
        dp    = 1'b0;
        an_n  = '1;
        for (int j = 0; j < NDIGITS; j++) begin
            if (idx == IW'(j)) begin
                digit = disp_value[4*j +: 4];
                dp    = disp_dp[j];
                if (slot_lit) begin
                    an_n[j] = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// tb_sevenseg_scanner: directed bench for sevenseg_scanner with NDIGITS=4,
// DIV=8, GUARD=2. Each 32-cycle frame starts at the negedge where frame_start
// is seen high (idx=0, cnt=0). The bench steps from that point one negedge
// per cycle.
module tb_sevenseg_scanner;

    localparam int ND = 4;
    localparam int DV = 8;
    localparam int GD = 2;

    logic          clk;
    logic          reset_n;
    logic          load_valid;
    logic          load_ready;
    logic [15:0]   load_value;
    logic [3:0]    load_dp;
    logic          blank_lz;
    logic [3:0]    digit;
    logic          dp;
    logic [3:0]    an_n;
    logic          frame_start;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dpv;
        logic        blank;
        logic [15:0] exp_digit;
        logic [15:0] exp_an;
        logic [3:0]  exp_dp;
    } vec_t;

    vec_t vecs[6];

    sevenseg_scanner #(.NDIGITS(ND), .DIV(DV), .GUARD(GD)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_value  (load_value),
        .load_dp     (load_dp),
        .blank_lz    (blank_lz),
        .digit       (digit),
        .dp          (dp),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Waits for the next frame_start. Returns at the negedge where it is high.
    task automatic wait_fs();
        int n;
        n = 0;
        @(negedge clk);
        while (!frame_start && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (!frame_start) chk("wait_fs_timeout", 32'(frame_start), 32'd1);
    endtask

    // Offers a value and completes one handshake. Starts and ends at a negedge.
    task automatic load(input logic [15:0] v, input logic [3:0] d);
        int n;
        load_value = v;
        load_dp    = d;
        load_valid = 1'b1;
        n = 0;
        while (!load_ready && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("load_ready_seen", 32'(load_ready), 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Checks one full frame against a vector. Called at a frame_start negedge.
    task automatic check_frame(input int k);
        for (int s = 0; s < ND; s++) begin
            for (int c = 0; c < DV; c++) begin
                if (c < GD) begin
                    chk($sformatf("v%0d_guard_s%0d_c%0d", k, s, c), 32'(an_n), 32'hF);
                end
                if (c == GD || c == DV - 1) begin
                    chk($sformatf("v%0d_an_s%0d_c%0d", k, s, c), 32'(an_n), 32'(vecs[k].exp_an[4*s +: 4]));
                    chk($sformatf("v%0d_digit_s%0d", k, s), 32'(digit), 32'(vecs[k].exp_digit[4*s +: 4]));
                    chk($sformatf("v%0d_dp_s%0d", k, s), 32'(dp), 32'(vecs[k].exp_dp[s]));
                end
                if (c == 4) begin
                    chk($sformatf("v%0d_fs_low_s%0d", k, s), 32'(frame_start), 32'd0);
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int n;
        int last;
        int pulses;
        logic prev_fs;

        vecs[0] = '{16'h1234, 4'b0010, 1'b0, 16'h1234, 16'h7BDE, 4'b0010};
        vecs[1] = '{16'h0050, 4'b0000, 1'b1, 16'h0050, 16'hFFDE, 4'b0000};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, 16'h0000, 16'hFFFE, 4'b0000};
        vecs[3] = '{16'h0050, 4'b0000, 1'b0, 16'h0050, 16'h7BDE, 4'b0000};
        vecs[4] = '{16'hA0F7, 4'b1001, 1'b1, 16'hA0F7, 16'h7BDE, 4'b1001};
        vecs[5] = '{16'h0800, 4'b1111, 1'b1, 16'h0800, 16'hFBDE, 4'b1111};

        // Reset.
        reset_n    = 1'b0;
        load_valid = 1'b0;
        load_value = 16'h0;
        load_dp    = 4'h0;
        blank_lz   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an_n", 32'(an_n), 32'hF);
        chk("rst_digit", 32'(digit), 32'h0);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_ready", 32'(load_ready), 32'd1);
        chk("rst_fs", 32'(frame_start), 32'd0);
        reset_n = 1'b1;

        // Table-driven frames.
        for (int k = 0; k < 6; k++) begin
            blank_lz = vecs[k].blank;
            load(vecs[k].value, vecs[k].dpv);
            wait_fs();
            check_frame(k);
        end

        // Frame-boundary bypass.
        blank_lz = 1'b0;
        wait_fs();
        repeat (31) @(negedge clk);
        load_value = 16'h9876;
        load_dp    = 4'b0100;
        load_valid = 1'b1;
        chk("byp_ready_at_boundary", 32'(load_ready), 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
        chk("byp_fs", 32'(frame_start), 32'd1);
        chk("byp_ready_after", 32'(load_ready), 32'd1);
        chk("byp_digit0", 32'(digit), 32'h6);
        repeat (10) @(negedge clk);
        chk("byp_digit1", 32'(digit), 32'h7);
        chk("byp_an1", 32'(an_n), 32'hD);
        repeat (8) @(negedge clk);
        chk("byp_dp2", 32'(dp), 32'd1);

        // Backpressure.
        wait_fs();
        repeat (10) @(negedge clk);
        load_value = 16'hAAAA;
        load_dp    = 4'h0;
        load_valid = 1'b1;
        chk("bp_ready_first", 32'(load_ready), 32'd1);
        @(negedge clk);
        chk("bp_ready_low", 32'(load_ready), 32'd0);
        load_value = 16'hBBBB;
        n = 0;
        while (!load_ready && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("bp_ready_rise", 32'(load_ready), 32'd1);
        chk("bp_ready_low_cycles", 32'(n), 32'd21);
        chk("bp_fs_at_ready", 32'(frame_start), 32'd1);
        chk("bp_digit_a", 32'(digit), 32'hA);
        @(negedge clk);
        load_valid = 1'b0;
        chk("bp_ready_after_b", 32'(load_ready), 32'd0);
        repeat (17) @(negedge clk);
        chk("bp_still_a", 32'(digit), 32'hA);
        chk("bp_an2", 32'(an_n), 32'hB);
        wait_fs();
        chk("bp_digit_b", 32'(digit), 32'hB);
        chk("bp_ready_end", 32'(load_ready), 32'd1);

        // Wrap timing.
        load(16'h1111, 4'h0);
        wait_fs();
        last    = -1;
        pulses  = 0;
        prev_fs = 1'b1;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if ($countones(~an_n) > 1) chk("wrap_an_onecold", 32'(an_n), 32'hF);
            if (frame_start) begin
                pulses++;
                chk("wrap_fs_width", 32'(prev_fs), 32'd0);
                if (last >= 0) chk("wrap_fs_period", 32'(i - last), 32'd32);
                last = i;
            end
            prev_fs = frame_start;
        end
        chk("wrap_fs_count", 32'(pulses), 32'd4);

        // Reset mid-scan with a pending value.
        load(16'h1234, 4'h0);
        wait_fs();
        repeat (3) @(negedge clk);
        load(16'h5555, 4'hF);
        repeat (17) @(negedge clk);
        chk("mrst_pre_ready", 32'(load_ready), 32'd0);
        chk("mrst_pre_an", 32'(an_n), 32'hB);
        chk("mrst_pre_digit", 32'(digit), 32'h2);
        reset_n = 1'b0;
        #1;
        chk("mrst_an_n", 32'(an_n), 32'hF);
        chk("mrst_digit", 32'(digit), 32'h0);
        chk("mrst_dp", 32'(dp), 32'h0);
        chk("mrst_ready", 32'(load_ready), 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i <= 42; i++) begin
            @(negedge clk);
            if (i == 1) chk("mrst_c1_an", 32'(an_n), 32'hF);
            if (i == 2) chk("mrst_c2_an", 32'(an_n), 32'hE);
            if (i == 31) chk("mrst_fs_early", 32'(frame_start), 32'd0);
            if (i == 32) chk("mrst_fs", 32'(frame_start), 32'd1);
            if (i == 42) begin
                chk("mrst_discard_digit", 32'(digit), 32'h0);
                chk("mrst_discard_an", 32'(an_n), 32'hD);
                chk("mrst_discard_ready", 32'(load_ready), 32'd1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
